// File: rtl/regfile_arbiter_if.sv
// Request/grant and register-file write bus between the requesters and regfile_arbiter.
interface regfile_arbiter_if;
  logic        A_REQ;
  logic [2:0]  A_DR;
  logic [15:0] A_DATA;
  logic        A_GNT;
  logic        B_REQ;
  logic [2:0]  B_DR;
  logic [15:0] B_DATA;
  logic        B_GNT;
  logic        CLR_START;
  logic        CLR_BUSY;
  logic        LD_REG;
  logic [2:0]  DR;
  logic [15:0] REGFILE_IN;

  modport master (
    output A_REQ, A_DR, A_DATA, B_REQ, B_DR, B_DATA, CLR_START,
    input  A_GNT, B_GNT, CLR_BUSY, LD_REG, DR, REGFILE_IN
  );

  modport slave (
    input  A_REQ, A_DR, A_DATA, B_REQ, B_DR, B_DATA, CLR_START,
    output A_GNT, B_GNT, CLR_BUSY, LD_REG, DR, REGFILE_IN
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin write arbiter for an 8x16 register file, with an
// 8-cycle sequential clear of all registers.
module regfile_arbiter (
  input  logic             Clk,
  input  logic             Reset,
  regfile_arbiter_if.slave bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic        last_q;      // 1: B granted most recently (A wins next tie)
  logic        ld_reg_q;
  logic [2:0]  dr_q;
  logic [15:0] regfile_in_q;
  logic        clr_busy_q;

  logic        arb_en;
  logic        gnt_a;
  logic        gnt_b;

  // Grants are gated by Reset directly so they drop as soon as reset asserts.
  always_comb begin
    arb_en = Reset && (state_q == IDLE) && !bus.CLR_START;
    gnt_a  = arb_en && bus.A_REQ && (!bus.B_REQ || last_q);
    gnt_b  = arb_en && bus.B_REQ && (!bus.A_REQ || !last_q);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      ld_reg_q     <= 1'b0;
      dr_q         <= '0;
      regfile_in_q <= '0;
      clr_busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.CLR_START) begin
            // First clear write is presented on entry so LD_REG lines up with CLR_BUSY.
            state_q      <= CLEAR;
            cnt_q        <= '0;
            ld_reg_q     <= 1'b1;
            dr_q         <= '0;
            regfile_in_q <= '0;
            clr_busy_q   <= 1'b1;
          end else begin
            ld_reg_q <= gnt_a || gnt_b;
            if (gnt_a) begin
              dr_q         <= bus.A_DR;
              regfile_in_q <= bus.A_DATA;
              last_q       <= 1'b0;
            end else if (gnt_b) begin
              dr_q         <= bus.B_DR;
              regfile_in_q <= bus.B_DATA;
              last_q       <= 1'b1;
            end
          end
        end
        CLEAR: begin
          if (cnt_q == 3'd7) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ld_reg_q   <= 1'b0;
            clr_busy_q <= 1'b0;
          end else begin
            cnt_q        <= cnt_q + 3'd1;
            ld_reg_q     <= 1'b1;
            dr_q         <= cnt_q + 3'd1;
            regfile_in_q <= '0;
            clr_busy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.A_GNT      = gnt_a;
  assign bus.B_GNT      = gnt_b;
  assign bus.LD_REG     = ld_reg_q;
  assign bus.DR         = dr_q;
  assign bus.REGFILE_IN = regfile_in_q;
  assign bus.CLR_BUSY   = clr_busy_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: arbitration, write timing, clear sequence, async reset.
module tb_regfile_arbiter;

  logic Clk;
  logic Reset;
  int   n_assert;
  int   n_fail;

  regfile_arbiter_if bus ();

  regfile_arbiter dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic aq, input logic [2:0] adr, input logic [15:0] ad,
                       input logic bq, input logic [2:0] bdr, input logic [15:0] bd,
                       input logic clr);
    bus.A_REQ = aq;  bus.A_DR = adr;  bus.A_DATA = ad;
    bus.B_REQ = bq;  bus.B_DR = bdr;  bus.B_DATA = bd;
    bus.CLR_START = clr;
  endtask

  // One clock: drive at negedge, check grants, then check registered outputs after posedge.
  // DR/REGFILE_IN are only compared when a write is expected.
  task automatic step(input string tag,
                      input logic aq, input logic [2:0] adr, input logic [15:0] ad,
                      input logic bq, input logic [2:0] bdr, input logic [15:0] bd,
                      input logic clr,
                      input logic ega, input logic egb,
                      input logic eld, input logic [2:0] edr, input logic [15:0] edata,
                      input logic ebusy);
    @(negedge Clk);
    drive(aq, adr, ad, bq, bdr, bd, clr);
    #1;
    chk({tag, ".A_GNT"}, 32'(bus.A_GNT), 32'(ega));
    chk({tag, ".B_GNT"}, 32'(bus.B_GNT), 32'(egb));
    @(posedge Clk);
    #1;
    chk({tag, ".LD_REG"}, 32'(bus.LD_REG), 32'(eld));
    chk({tag, ".CLR_BUSY"}, 32'(bus.CLR_BUSY), 32'(ebusy));
    if (eld) begin
      chk({tag, ".DR"}, 32'(bus.DR), 32'(edr));
      chk({tag, ".REGFILE_IN"}, 32'(bus.REGFILE_IN), 32'(edata));
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    Reset    = 1'b0;
    drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0);
    #2;
    chk("rst.A_GNT", 32'(bus.A_GNT), 32'd0);
    chk("rst.B_GNT", 32'(bus.B_GNT), 32'd0);
    chk("rst.LD_REG", 32'(bus.LD_REG), 32'd0);
    chk("rst.DR", 32'(bus.DR), 32'd0);
    chk("rst.REGFILE_IN", 32'(bus.REGFILE_IN), 32'd0);
    chk("rst.CLR_BUSY", 32'(bus.CLR_BUSY), 32'd0);
    @(posedge Clk); #1;
    chk("rst_clk.LD_REG", 32'(bus.LD_REG), 32'd0);
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    Reset = 1'b1;

    // Round-robin tie after reset: A, B, A, B
    step("tie0", 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, 1, 0, 1, 3'd1, 16'hAAAA, 0);
    step("tie1", 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, 0, 1, 1, 3'd2, 16'hBBBB, 0);
    step("tie2", 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, 1, 0, 1, 3'd1, 16'hAAAA, 0);
    step("tie3", 1, 3'd1, 16'hAAAA, 1, 3'd2, 16'hBBBB, 0, 0, 1, 1, 3'd2, 16'hBBBB, 0);
    step("idle", 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0, 0, 0, 3'd0, 16'h0, 0);

    // Single A request
    step("aonly", 1, 3'd3, 16'h1234, 0, 3'd0, 16'h0, 0, 1, 0, 1, 3'd3, 16'h1234, 0);
    step("bonly", 0, 3'd0, 16'h0, 1, 3'd6, 16'h0F0F, 0, 0, 1, 1, 3'd6, 16'h0F0F, 0);

    // Clear with A pending: A waits, then granted in first IDLE cycle
    step("clr_start", 1, 3'd5, 16'h5555, 0, 3'd0, 16'h0, 1, 0, 0, 1, 3'd0, 16'h0, 1);
    for (int unsigned i = 0; i < 8; i++) begin
      step($sformatf("clr%0d", i), 1, 3'd5, 16'h5555, 0, 3'd0, 16'h0, 0, 0, 0,
           (i < 7), 3'(i + 1), 16'h0, (i < 7));
    end
    step("clr_after", 1, 3'd5, 16'h5555, 0, 3'd0, 16'h0, 0, 1, 0, 1, 3'd5, 16'h5555, 0);

    // CLR_START re-pulsed at third CLEAR cycle is ignored
    step("rclr_start", 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 0, 0, 1, 3'd0, 16'h0, 1);
    for (int unsigned i = 0; i < 8; i++) begin
      step($sformatf("rclr%0d", i), 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, (i == 2), 0, 0,
           (i < 7), 3'(i + 1), 16'h0, (i < 7));
    end
    step("rclr_done", 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0, 0, 0, 3'd0, 16'h0, 0);

    // Async reset after the fourth clear write
    step("aclr_start", 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 1, 0, 0, 1, 3'd0, 16'h0, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      step($sformatf("aclr%0d", i), 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0, 0,
           1, 3'(i + 1), 16'h0, 1);
    end
    #2;
    drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0);
    Reset = 1'b0;
    #1;
    chk("arst.LD_REG", 32'(bus.LD_REG), 32'd0);
    chk("arst.CLR_BUSY", 32'(bus.CLR_BUSY), 32'd0);
    chk("arst.A_GNT", 32'(bus.A_GNT), 32'd0);
    chk("arst.B_GNT", 32'(bus.B_GNT), 32'd0);
    @(posedge Clk); #1;
    chk("arst_hold.LD_REG", 32'(bus.LD_REG), 32'd0);
    @(negedge Clk);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0);
    Reset = 1'b1;
    step("post_b", 0, 3'd0, 16'h0, 1, 3'd4, 16'hBEEF, 0, 0, 1, 1, 3'd4, 16'hBEEF, 0);
    step("post_tie", 1, 3'd7, 16'hCAFE, 1, 3'd4, 16'hBEEF, 0, 1, 0, 1, 3'd7, 16'hCAFE, 0);
    step("post_idle", 0, 3'd0, 16'h0, 0, 3'd0, 16'h0, 0, 0, 0, 0, 3'd0, 16'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
